// File: rtl/key_press_classifier.sv
// key_press_classifier: classifies a debounced key into short, double, long and auto-repeat events.
//   I_clk       rising-edge clock
//   I_rst_n     asynchronous active-low reset
//   I_key_level debounced key level, 1 = pressed
//   O_short     one-cycle pulse for a single short click
//   O_double    one-cycle pulse for a double click
//   O_long      one-cycle pulse when the long-press threshold is reached
//   O_repeat    one-cycle auto-repeat pulse while held after O_long
//   O_busy      high whenever the FSM is not in IDLE
module key_press_classifier #(
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned DCLICK_CYC = 15_000_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_key_level,
  output logic O_short,
  output logic O_double,
  output logic O_long,
  output logic O_repeat,
  output logic O_busy
);
  typedef enum logic [2:0] {ARM, IDLE, PRESS1, HOLD, WAIT2, PRESS2} state_t;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] DCL_LAST  = CNT_W'(DCLICK_CYC - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d, double_q, double_d;
  logic             long_q, long_d, repeat_q, repeat_d;
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      ARM:    if (!I_key_level) state_d = IDLE;
      IDLE:   if (I_key_level) state_d = PRESS1;
      // reaching the threshold commits to a long press even if the release lands on that same edge
      PRESS1: if (cnt_q == LONG_LAST) begin
                state_d = HOLD;
                long_d  = 1'b1;
              end else if (!I_key_level) state_d = WAIT2;
      HOLD:   if (!I_key_level) state_d = IDLE;
              else repeat_d = (cnt_q == REP_LAST);
      // a press beats a timeout on the same edge
      WAIT2:  if (I_key_level) state_d = PRESS2;
              else if (cnt_q == DCL_LAST) begin
                state_d = IDLE;
                short_d = 1'b1;
              end
      PRESS2: if (!I_key_level) begin
                state_d  = IDLE;
                double_d = 1'b1;
              end
      default: state_d = ARM;
    endcase
    // each repeat pulse restarts the period, so the counter is cleared as on a state change
    cnt_d = (state_d != state_q || repeat_d) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  end
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= ARM;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end
  assign O_short  = short_q;
  assign O_double = double_q;
  assign O_long   = long_q;
  assign O_repeat = repeat_q;
  assign O_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_key_press_classifier.sv
// tb_key_press_classifier: directed self-checking bench for key_press_classifier.
module tb_key_press_classifier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key = 1'b0;
  logic o_short, o_double, o_long, o_repeat, o_busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_short, n_double, n_long, n_rep, multi;
  int short_cyc, double_cyc, long_cyc;
  int rep_cyc [0:3];
  key_press_classifier #(
    .LONG_CYC(20), .REPEAT_CYC(5), .DCLICK_CYC(8), .CNT_W(8)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_key_level(key),
    .O_short(o_short), .O_double(o_double), .O_long(o_long),
    .O_repeat(o_repeat), .O_busy(o_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (o_short) begin n_short++; short_cyc = cyc; end
    if (o_double) begin n_double++; double_cyc = cyc; end
    if (o_long) begin n_long++; long_cyc = cyc; end
    if (o_repeat) begin
      if (n_rep < 4) rep_cyc[n_rep] = cyc;
      n_rep++;
    end
    if (int'(o_short) + int'(o_double) + int'(o_long) + int'(o_repeat) > 1) multi++;
  end
  task automatic clr();
    n_short = 0; n_double = 0; n_long = 0; n_rep = 0;
    short_cyc = -1; double_cyc = -1; long_cyc = -1;
    for (int i = 0; i < 4; i++) rep_cyc[i] = -1;
  endtask
  task automatic hold(input logic lvl, input int n);
    key = lvl;
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset();
    multi = 0;
    clr();
    #1;
    checks++; if ({o_short, o_double, o_long, o_repeat} !== 4'b0) begin errors++; $display("FAIL reset_events got %b exp 0000", {o_short, o_double, o_long, o_repeat}); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_arm got %b exp 1", o_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL arm_to_idle_busy got %b exp 0", o_busy); end
  endtask
  task automatic test_short();
    int r;
    clr();
    hold(1'b1, 5);
    r = cyc;
    hold(1'b0, 15);
    checks++; if (n_short !== 1) begin errors++; $display("FAIL short_count got %0d exp 1", n_short); end
    checks++; if (short_cyc !== r + 9) begin errors++; $display("FAIL short_time got %0d exp %0d", short_cyc, r + 9); end
    checks++; if (n_double + n_long + n_rep !== 0) begin errors++; $display("FAIL short_others got %0d exp 0", n_double + n_long + n_rep); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL short_busy got %b exp 0", o_busy); end
  endtask
  task automatic test_double();
    int r;
    clr();
    hold(1'b1, 3);
    hold(1'b0, 4);
    hold(1'b1, 3);
    r = cyc;
    hold(1'b0, 12);
    checks++; if (n_double !== 1) begin errors++; $display("FAIL double_count got %0d exp 1", n_double); end
    checks++; if (double_cyc !== r + 1) begin errors++; $display("FAIL double_time got %0d exp %0d", double_cyc, r + 1); end
    checks++; if (n_short !== 0) begin errors++; $display("FAIL double_no_short got %0d exp 0", n_short); end
  endtask
  task automatic test_long();
    int p;
    clr();
    p = cyc;
    hold(1'b1, 36);
    hold(1'b0, 15);
    checks++; if (n_long !== 1) begin errors++; $display("FAIL long_count got %0d exp 1", n_long); end
    checks++; if (long_cyc !== p + 21) begin errors++; $display("FAIL long_time got %0d exp %0d", long_cyc, p + 21); end
    checks++; if (n_rep !== 3) begin errors++; $display("FAIL repeat_count got %0d exp 3", n_rep); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rep_cyc[i] !== p + 26 + 5 * i) begin errors++; $display("FAIL repeat_time%0d got %0d exp %0d", i, rep_cyc[i], p + 26 + 5 * i); end
    end
    checks++; if (n_short + n_double !== 0) begin errors++; $display("FAIL long_no_click got %0d exp 0", n_short + n_double); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL long_busy got %b exp 0", o_busy); end
  endtask
  task automatic test_boundary();
    int p, r;
    clr();
    hold(1'b1, 19);
    r = cyc;
    hold(1'b0, 15);
    checks++; if (n_long !== 0) begin errors++; $display("FAIL b19_long got %0d exp 0", n_long); end
    checks++; if (n_short !== 1 || short_cyc !== r + 9) begin errors++; $display("FAIL b19_short got n=%0d t=%0d exp n=1 t=%0d", n_short, short_cyc, r + 9); end
    clr();
    p = cyc;
    hold(1'b1, 20);
    hold(1'b0, 15);
    checks++; if (n_long !== 1 || long_cyc !== p + 21) begin errors++; $display("FAIL b20_long got n=%0d t=%0d exp n=1 t=%0d", n_long, long_cyc, p + 21); end
    checks++; if (n_short + n_double + n_rep !== 0) begin errors++; $display("FAIL b20_others got %0d exp 0", n_short + n_double + n_rep); end
  endtask
  task automatic test_reset_held();
    int r;
    clr();
    key = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 10);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL held_busy got %b exp 1", o_busy); end
    hold(1'b0, 3);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL held_release_busy got %b exp 0", o_busy); end
    checks++; if (n_short + n_double + n_long + n_rep !== 0) begin errors++; $display("FAIL held_events got %0d exp 0", n_short + n_double + n_long + n_rep); end
    hold(1'b1, 5);
    r = cyc;
    hold(1'b0, 15);
    checks++; if (n_short !== 1 || short_cyc !== r + 9) begin errors++; $display("FAIL held_then_short got n=%0d t=%0d exp n=1 t=%0d", n_short, short_cyc, r + 9); end
  endtask
  task automatic test_reset_wait2();
    clr();
    hold(1'b1, 5);
    hold(1'b0, 3);
    rst_n = 1'b0;
    #1;
    checks++; if ({o_short, o_double, o_long, o_repeat} !== 4'b0) begin errors++; $display("FAIL w2rst_events got %b exp 0000", {o_short, o_double, o_long, o_repeat}); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL w2rst_busy got %b exp 1", o_busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 20);
    checks++; if (n_short + n_double + n_long + n_rep !== 0) begin errors++; $display("FAIL w2rst_no_event got %0d exp 0", n_short + n_double + n_long + n_rep); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL w2rst_idle got %b exp 0", o_busy); end
  endtask
  initial begin
    test_reset();
    test_short();
    test_double();
    test_long();
    test_boundary();
    test_reset_held();
    test_reset_wait2();
    checks++; if (multi !== 0) begin errors++; $display("FAIL one_hot got %0d exp 0", multi); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_press_classifier.md
KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

Interface
REQ-001 The block SHALL have parameter LONG_CYC, default 50_000_000, meaning the number of consecutive pressed cycles that declares a long press (legal range 2..2^CNT_W-1).
REQ-002 The block SHALL have parameter REPEAT_CYC, default 10_000_000, meaning the auto-repeat period while held after a long press (legal range 2..2^CNT_W-1).
REQ-003 The block SHALL have parameter DCLICK_CYC, default 15_000_000, meaning the window after a release within which a second press forms a double click (legal range 2..2^CNT_W-1).
REQ-004 The block SHALL have parameter CNT_W, default 26, meaning the width of the single internal cycle counter.
REQ-005 The block SHALL have port I_clk, input, 1 bit: the single clock; every register SHALL be clocked on its rising edge.
REQ-006 The block SHALL have port I_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port I_key_level, input, 1 bit: the debounced key level from the debounce stage, 1 = pressed, already synchronous to I_clk.
REQ-008 The block SHALL have port O_short, output, 1 bit: one-cycle pulse for a single short click.
REQ-009 The block SHALL have port O_double, output, 1 bit: one-cycle pulse for a double click.
REQ-010 The block SHALL have port O_long, output, 1 bit: one-cycle pulse when the long-press threshold is reached.
REQ-011 The block SHALL have port O_repeat, output, 1 bit: one-cycle auto-repeat pulse while the key is still held after O_long.
REQ-012 The block SHALL have port O_busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL use the FSM states ARM, IDLE, PRESS1, HOLD, WAIT2 and PRESS2, with one shared counter that is cleared on every state change.
REQ-014 The FSM SHALL leave ARM for IDLE on the first edge that samples I_key_level=0; no press SHALL be detected in ARM.
REQ-015 The FSM SHALL go from IDLE to PRESS1 on the edge that samples I_key_level=1.
REQ-016 In PRESS1, if release is sampled while the counter is below LONG_CYC-1, the FSM SHALL go to WAIT2.
REQ-017 In PRESS1, if the key is still pressed when the counter reaches LONG_CYC-1, the FSM SHALL go to HOLD and O_long SHALL be high during the cycle after that edge, i.e. exactly LONG_CYC cycles after the press-sampling edge.
REQ-018 In HOLD, O_repeat SHALL pulse every REPEAT_CYC cycles, with the first pulse REPEAT_CYC cycles after O_long.
REQ-019 In HOLD, a sampled release SHALL send the FSM to IDLE with no further event output.
REQ-020 In WAIT2, a press sampled while the counter is below DCLICK_CYC-1 SHALL send the FSM to PRESS2.
REQ-021 In WAIT2, when the counter reaches DCLICK_CYC-1 with no press, O_short SHALL be high during the next cycle (DCLICK_CYC cycles after the release-sampling edge) and the FSM SHALL go to IDLE.
REQ-022 In PRESS2, a sampled release SHALL send the FSM to IDLE and O_double SHALL be high during the next cycle, regardless of how long PRESS2 lasted; PRESS2 SHALL have no long or repeat path.
REQ-023 All event outputs SHALL be registered, at most one SHALL be high in any cycle, and each pulse SHALL last exactly one cycle.
REQ-024 The counter SHALL saturate and never wrap.
REQ-025 A press and a WAIT2 timeout landing on the same edge SHALL resolve as the press (go to PRESS2, no O_short).
REQ-026 O_busy SHALL be combinational from the state register.

Reset
REQ-027 While I_rst_n=0, the FSM SHALL be forced to ARM, the counter to 0, and O_short, O_double, O_long, O_repeat to 0, all asynchronously.
REQ-028 O_busy SHALL be 1 while the FSM is in ARM.
REQ-029 Asserting reset mid-operation SHALL discard any pending event; no event pulse SHALL appear after reset deassertion until a new complete gesture has been seen.
REQ-030 A key already held when reset deasserts SHALL produce no event until it has been released and pressed again.

Verification (LONG_CYC=20, REPEAT_CYC=5, DCLICK_CYC=8)
REQ-031 The bench SHALL cover: after ARM->IDLE, press 5 cycles then release -> single O_short pulse 8 cycles after the release edge; no other pulses.
REQ-032 The bench SHALL cover: press 3, release 4, press 3, release -> O_double 1 cycle after the second release edge; O_short never asserted.
REQ-033 The bench SHALL cover: hold 36 cycles then release -> O_long at cycle 20, O_repeat at cycles 25, 30 and 35; no O_short or O_double after release.
REQ-034 The bench SHALL cover the long-press boundary: press exactly 19 cycles -> WAIT2 path, O_short; press exactly 20 cycles -> O_long, no O_short.
REQ-035 The bench SHALL cover reset: key held through reset deassertion for 10 cycles, then released -> no events and O_busy falls after release; a following 5-cycle press -> normal O_short.
REQ-036 The bench SHALL cover: I_rst_n pulsed low mid-WAIT2 -> all outputs 0 immediately, no O_short ever emitted for that click.
